// File: rtl/pipelined_adder_if.sv
// Stream bundle for pipelined_adder: operand beat in, sum beat out, valid/ready on both sides.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunks, one chunk per pipeline stage, with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_c;
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [CHUNK:0]    chunk_sum [STAGES];

    // A stage may load if the consumer takes the output or any stage at or above it is empty,
    // which is the unrolled form of the ready chain and lets bubbles collapse under stall.
    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        up_valid[0] = bus.in_valid;
        up_a[0]     = bus.a;
        up_b[0]     = bus.b;
        up_s[0]     = '0;
        up_c[0]     = bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = valid_q[k-1];
            up_a[k]     = a_q[k-1];
            up_b[k]     = b_q[k-1];
            up_s[k]     = s_q[k-1];
            up_c[k]     = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, up_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, up_b[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, up_c[k]};
            s_d[k]                   = up_s[k];
            s_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
            c_d[k]                   = chunk_sum[k][CHUNK];
        end
    end

    // Only the output stage data is reset; inner data is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            s_q[STAGES-1]    <= '0;
            c_q[STAGES-1]    <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        a_q[k] <= up_a[k];
                        b_q[k] <= up_b[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (up_a[STAGES-1][WIDTH-1] == up_b[STAGES-1][WIDTH-1])
                && (s_d[STAGES-1][WIDTH-1] != up_a[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (load[STAGES-1] && up_valid[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=4); a driver pushes expected results,
// an independent monitor pops and compares them whenever the DUT presents an output.
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   acceptCount = 0;
    int   stallCount = 0;

    // Backpressure vectors: a, b, cin and hand-computed sum, cout, ovf.
    logic [7:0] bpA   [6] = '{8'h11, 8'hF0, 8'h80, 8'h0F, 8'hAA, 8'h7F};
    logic [7:0] bpB   [6] = '{8'h22, 8'h20, 8'h80, 8'h0F, 8'h55, 8'h01};
    logic       bpCin [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [7:0] bpSum [6] = '{8'h33, 8'h11, 8'h00, 8'h1F, 8'h00, 8'h80};
    logic       bpCo  [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       bpOvf [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got sum=0x%0h want no beat", bus.sum);
        end else begin
            e = sb.pop_front();
            checkVal("sum", 32'(bus.sum), 32'(e.sum));
            checkVal("cout", 32'(bus.cout), 32'(e.cout));
`ifdef PIPE_ADDER_OVF_EN
            checkVal("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
    endtask

    // Called just after a falling edge; returns at the falling edge following acceptance.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                 input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int   waits;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        waits        = 0;
        #1;
        while (!bus.in_ready && waits < 200) begin
            stallCount++;
            waits++;
            @(negedge clk);
            #1;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            sb.push_back(e);
            acceptCount++;
        end
        @(negedge clk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || bus.out_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
        @(negedge clk);
    endtask

    // Monitor: consume on handshake, otherwise verify the stalled output holds the head beat.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid) begin
                if (bus.out_ready) begin
                    checkOutput();
                end else if (sb.size() != 0) begin
                    checkVal("held_sum", 32'(bus.sum), 32'(sb[0].sum));
                    checkVal("held_cout", 32'(bus.cout), 32'(sb[0].cout));
                end
            end
        end
    end

    initial begin
        #100000;
        bad++;
        total++;
        $display("[TB] FAIL watchdog: got no finish want finish before 100000");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        $display("[TB] reset");
        @(posedge clk);
        @(negedge clk);
        checkVal("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("reset_sum", 32'(bus.sum), 32'd0);
        checkVal("reset_cout", 32'(bus.cout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        $display("[TB] latency and wrap-around");
        bus.out_ready = 1'b1;
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        cnt = 1;
        #1;
        while (!bus.out_valid && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        checkVal("latency", 32'(cnt), 32'd4);
        waitDrain();
        applyStimulus(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        waitDrain();

        $display("[TB] back-to-back beats");
        stallCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i), 8'(2 * i), 1'b1, 8'(3 * i + 1), 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        checkVal("b2b_stalls", 32'(stallCount), 32'd0);
        waitDrain();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        acceptCount   = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(bpA[i], bpB[i], bpCin[i], bpSum[i], bpCo[i], bpOvf[i]);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                checkVal("full_in_ready", 32'(bus.in_ready), 32'd0);
                checkVal("full_accepted", 32'(acceptCount), 32'd4);
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-operation");
        bus.out_ready = 1'b0;
        applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        applyStimulus(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(8'hFE, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkVal("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        checkVal("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("midrst_sum", 32'(bus.sum), 32'd0);
        checkVal("midrst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkVal("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(negedge clk);
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
